// File: rtl/ball_collision_scanner_pkg.sv
// Shared billiard definitions: fixed-point widths, ball record, scanner FSM states.
// Imported by the ball-state scanners and the collision/wall/pocket stages.
package billiard_pkg;

  localparam int WIDTH      = 32;
  localparam int FRAC_WIDTH = 30;
  localparam int N_MAX      = 16;
  localparam int IDX_W      = $clog2(N_MAX);

  localparam logic signed [WIDTH-1:0] ONE = WIDTH'(64'sd1 <<< FRAC_WIDTH);

  typedef enum logic [2:0] {
    IDLE,
    ADDR_I,
    ADDR_J,
    CHECK,
    EMIT,
    FIN
  } scanState_t;

  typedef struct packed {
    logic signed [WIDTH-1:0] x;
    logic signed [WIDTH-1:0] y;
    logic signed [WIDTH-1:0] vx;
    logic signed [WIDTH-1:0] vy;
  } ball_t;

  // Counts above the memory depth would let the 4-bit pair indices wrap.
  function automatic logic [IDX_W:0] clampCount(input logic [IDX_W:0] n);
    return (n > (IDX_W+1)'(N_MAX)) ? (IDX_W+1)'(N_MAX) : n;
  endfunction

endpackage

// File: rtl/ball_collision_scanner_if.sv
// Bundle between the collision scanner, the ball-state RAM and the post-collision stage.
// master = scanner side, slave = surrounding system (RAM, controller, downstream).
interface ball_collision_scanner_if;
  import billiard_pkg::*;

  logic                    start;
  logic [IDX_W:0]          n_balls;
  logic signed [WIDTH-1:0] diam_sq;

  logic [IDX_W-1:0]        rd_addr;
  logic signed [WIDTH-1:0] rd_x;
  logic signed [WIDTH-1:0] rd_y;
  logic signed [WIDTH-1:0] rd_vx;
  logic signed [WIDTH-1:0] rd_vy;

  logic                    pair_valid;
  logic                    pair_ready;
  logic [IDX_W-1:0]        pair_i;
  logic [IDX_W-1:0]        pair_j;
  logic signed [WIDTH-1:0] x0;
  logic signed [WIDTH-1:0] y0;
  logic signed [WIDTH-1:0] v0_x;
  logic signed [WIDTH-1:0] v0_y;
  logic signed [WIDTH-1:0] x1;
  logic signed [WIDTH-1:0] y1;
  logic signed [WIDTH-1:0] v1_x;
  logic signed [WIDTH-1:0] v1_y;

  logic                    busy;
  logic                    done;
  logic [2*IDX_W-1:0]      pair_count;

  modport master (
    input  start, n_balls, diam_sq,
    input  rd_x, rd_y, rd_vx, rd_vy,
    input  pair_ready,
    output rd_addr,
    output pair_valid, pair_i, pair_j,
    output x0, y0, v0_x, v0_y, x1, y1, v1_x, v1_y,
    output busy, done, pair_count
  );

  modport slave (
    output start, n_balls, diam_sq,
    output rd_x, rd_y, rd_vx, rd_vy,
    output pair_ready,
    input  rd_addr,
    input  pair_valid, pair_i, pair_j,
    input  x0, y0, v0_x, v0_y, x1, y1, v1_x, v1_y,
    input  busy, done, pair_count
  );

endinterface

// File: rtl/ball_collision_scanner_pair_hit_test.sv
// Combinational overlap-and-approach test for two balls, full precision, no truncation.
// Also used by the wall/pocket stages, hence the exported d2/dot taps.
module pair_hit_test #(
  parameter int WIDTH      = 32,
  parameter int FRAC_WIDTH = 30
) (
  input  logic signed [WIDTH-1:0]   i_x0,
  input  logic signed [WIDTH-1:0]   i_y0,
  input  logic signed [WIDTH-1:0]   i_vx0,
  input  logic signed [WIDTH-1:0]   i_vy0,
  input  logic signed [WIDTH-1:0]   i_x1,
  input  logic signed [WIDTH-1:0]   i_y1,
  input  logic signed [WIDTH-1:0]   i_vx1,
  input  logic signed [WIDTH-1:0]   i_vy1,
  input  logic signed [WIDTH-1:0]   i_diamSq,
  output logic                      o_hit,
  output logic signed [2*WIDTH+2:0] o_d2,
  output logic signed [2*WIDTH+2:0] o_dot
);

  localparam int PW = 2*WIDTH+3;

  logic signed [WIDTH:0] w_dx;
  logic signed [WIDTH:0] w_dy;
  logic signed [WIDTH:0] w_dvx;
  logic signed [WIDTH:0] w_dvy;
  logic signed [PW-1:0]  w_dxE;
  logic signed [PW-1:0]  w_dyE;
  logic signed [PW-1:0]  w_dvxE;
  logic signed [PW-1:0]  w_dvyE;
  logic signed [PW-1:0]  w_lim;

  // Differences need one extra bit so full-range coordinates cannot overflow.
  assign w_dx  = {i_x1[WIDTH-1],  i_x1}  - {i_x0[WIDTH-1],  i_x0};
  assign w_dy  = {i_y1[WIDTH-1],  i_y1}  - {i_y0[WIDTH-1],  i_y0};
  assign w_dvx = {i_vx1[WIDTH-1], i_vx1} - {i_vx0[WIDTH-1], i_vx0};
  assign w_dvy = {i_vy1[WIDTH-1], i_vy1} - {i_vy0[WIDTH-1], i_vy0};

  assign w_dxE  = PW'(w_dx);
  assign w_dyE  = PW'(w_dy);
  assign w_dvxE = PW'(w_dvx);
  assign w_dvyE = PW'(w_dvy);

  assign o_d2  = w_dxE * w_dxE  + w_dyE * w_dyE;
  assign o_dot = w_dxE * w_dvxE + w_dyE * w_dvyE;

  // d2 carries 2*FRAC_WIDTH fraction bits, so the threshold is rescaled to match.
  assign w_lim = PW'(i_diamSq) <<< FRAC_WIDTH;

  assign o_hit = (o_d2 < w_lim) && o_dot[PW-1];

endmodule

// File: rtl/ball_collision_scanner.sv
// Walks every ball pair (i<j) once per start and streams colliding, approaching pairs
// to the post-collision velocity stage over a valid/ready handshake.
module ball_collision_scanner
  import billiard_pkg::*;
(
  input logic                      clk,
  input logic                      rst,
  ball_collision_scanner_if.master bus
);

  scanState_t                r_state;
  scanState_t                w_nextState;
  scanState_t                w_advanceState;
  logic [IDX_W:0]            r_nBalls;
  logic signed [WIDTH-1:0]   r_diamSq;
  logic [IDX_W-1:0]          r_i;
  logic [IDX_W-1:0]          r_j;
  ball_t                     r_ballI;
  ball_t                     r_ballJ;
  ball_t                     w_rdBall;
  logic [2*IDX_W-1:0]        r_pairCount;
  logic                      r_busy;
  logic                      r_done;
  logic                      w_hit;
  logic                      w_accept;
  logic                      w_handshake;
  logic                      w_advance;
  logic                      w_moreJ;
  logic                      w_moreI;
  logic [IDX_W:0]            w_startCount;
  logic signed [2*WIDTH+2:0] w_unusedD2;
  logic signed [2*WIDTH+2:0] w_unusedDot;

  assign w_rdBall = {bus.rd_x, bus.rd_y, bus.rd_vx, bus.rd_vy};

  pair_hit_test #(
    .WIDTH      (WIDTH),
    .FRAC_WIDTH (FRAC_WIDTH)
  ) u_hitTest (
    .i_x0     (r_ballI.x),
    .i_y0     (r_ballI.y),
    .i_vx0    (r_ballI.vx),
    .i_vy0    (r_ballI.vy),
    .i_x1     (w_rdBall.x),
    .i_y1     (w_rdBall.y),
    .i_vx1    (w_rdBall.vx),
    .i_vy1    (w_rdBall.vy),
    .i_diamSq (r_diamSq),
    .o_hit    (w_hit),
    .o_d2     (w_unusedD2),
    .o_dot    (w_unusedDot)
  );

  // busy stays high through the done cycle so a start coinciding with done is ignored.
  assign w_accept     = (r_state == IDLE) && bus.start && !r_busy;
  assign w_startCount = clampCount(bus.n_balls);
  assign w_handshake  = (r_state == EMIT) && bus.pair_ready;
  assign w_advance    = ((r_state == CHECK) && !w_hit) || w_handshake;
  assign w_moreJ      = ({1'b0, r_j} + (IDX_W+1)'(1)) < r_nBalls;
  assign w_moreI      = ({1'b0, r_i} + (IDX_W+1)'(2)) < r_nBalls;

  always_comb begin
    w_advanceState = FIN;
    if (w_moreJ) begin
      w_advanceState = ADDR_J;
    end else if (w_moreI) begin
      w_advanceState = ADDR_I;
    end
  end

  always_comb begin
    w_nextState = r_state;
    case (r_state)
      IDLE: begin
        if (w_accept) begin
          w_nextState = (w_startCount < (IDX_W+1)'(2)) ? FIN : ADDR_I;
        end
      end
      ADDR_I:  w_nextState = ADDR_J;
      ADDR_J:  w_nextState = CHECK;
      CHECK:   w_nextState = w_hit ? EMIT : w_advanceState;
      EMIT: begin
        if (bus.pair_ready) begin
          w_nextState = w_advanceState;
        end
      end
      FIN:     w_nextState = IDLE;
      default: w_nextState = IDLE;
    endcase
  end

  // Outside ADDR_J the RAM is kept pointed at ball i, so the data seen in ADDR_J is always ball i.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= IDLE;
      r_nBalls    <= '0;
      r_diamSq    <= '0;
      r_i         <= '0;
      r_j         <= '0;
      r_ballI     <= '0;
      r_ballJ     <= '0;
      r_pairCount <= '0;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
    end else begin
      r_state <= w_nextState;
      r_done  <= (r_state == FIN);

      if (w_accept) begin
        r_nBalls    <= w_startCount;
        r_diamSq    <= bus.diam_sq;
        r_i         <= '0;
        r_j         <= IDX_W'(1);
        r_pairCount <= '0;
        r_busy      <= 1'b1;
      end else if (r_done) begin
        r_busy <= 1'b0;
      end

      if (r_state == ADDR_J) begin
        r_ballI <= w_rdBall;
      end
      if ((r_state == CHECK) && w_hit) begin
        r_ballJ <= w_rdBall;
      end
      if (w_handshake) begin
        r_pairCount <= r_pairCount + (2*IDX_W)'(1);
      end

      if (w_advance) begin
        if (w_moreJ) begin
          r_j <= r_j + IDX_W'(1);
        end else if (w_moreI) begin
          r_i <= r_i + IDX_W'(1);
          r_j <= r_i + IDX_W'(2);
        end
      end

      if (r_state == FIN) begin
        r_i <= '0;
        r_j <= '0;
      end
    end
  end

  assign bus.rd_addr    = (r_state == ADDR_J) ? r_j : r_i;
  assign bus.pair_valid = (r_state == EMIT);
  assign bus.pair_i     = r_i;
  assign bus.pair_j     = r_j;
  assign bus.x0         = r_ballI.x;
  assign bus.y0         = r_ballI.y;
  assign bus.v0_x       = r_ballI.vx;
  assign bus.v0_y       = r_ballI.vy;
  assign bus.x1         = r_ballJ.x;
  assign bus.y1         = r_ballJ.y;
  assign bus.v1_x       = r_ballJ.vx;
  assign bus.v1_y       = r_ballJ.vy;
  assign bus.busy       = r_busy;
  assign bus.done       = r_done;
  assign bus.pair_count = r_pairCount;

endmodule

// File: tb/tb_ball_collision_scanner.sv
// Bench for ball_collision_scanner: directed collision cases plus random scans,
// checked against an all-pairs reference computed with wide plain arithmetic.
module tb_ball_collision_scanner;
  import billiard_pkg::*;

  logic clk = 1'b0;
  logic rst;

  ball_collision_scanner_if bus ();

  ball_collision_scanner dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  logic signed [WIDTH-1:0] memX  [N_MAX];
  logic signed [WIDTH-1:0] memY  [N_MAX];
  logic signed [WIDTH-1:0] memVx [N_MAX];
  logic signed [WIDTH-1:0] memVy [N_MAX];

  // Ball-state RAM: one cycle read latency.
  always @(posedge clk) begin
    bus.rd_x  <= memX[bus.rd_addr];
    bus.rd_y  <= memY[bus.rd_addr];
    bus.rd_vx <= memVx[bus.rd_addr];
    bus.rd_vy <= memVy[bus.rd_addr];
  end

  int checks;
  int failures;

  task automatic checkOutput(input string tag, input logic [263:0] got, input logic [263:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("[TB] FAIL %s got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  task automatic loadBall(input int idx, input logic signed [WIDTH-1:0] x, input logic signed [WIDTH-1:0] y,
                          input logic signed [WIDTH-1:0] vx, input logic signed [WIDTH-1:0] vy);
    memX[idx]  = x;
    memY[idx]  = y;
    memVx[idx] = vx;
    memVy[idx] = vy;
  endtask

  // Collision rule: squared distance strictly below (2r)^2, and closing velocity.
  function automatic bit refHit(input int i, input int j, input logic signed [WIDTH-1:0] dsq);
    logic signed [127:0] dx, dy, dvx, dvy, d2, dot, lim;
    dx  = 128'(memX[j])  - 128'(memX[i]);
    dy  = 128'(memY[j])  - 128'(memY[i]);
    dvx = 128'(memVx[j]) - 128'(memVx[i]);
    dvy = 128'(memVy[j]) - 128'(memVy[i]);
    d2  = dx * dx + dy * dy;
    dot = dx * dvx + dy * dvy;
    lim = 128'(dsq) * (128'sd1 <<< FRAC_WIDTH);
    return (d2 < lim) && (dot < 0);
  endfunction

  function automatic logic [263:0] packPair(input int i, input int j);
    return {IDX_W'(i), IDX_W'(j), memX[i], memY[i], memVx[i], memVy[i],
            memX[j], memY[j], memVx[j], memVy[j]};
  endfunction

  function automatic logic [263:0] observedPair();
    return {bus.pair_i, bus.pair_j, bus.x0, bus.y0, bus.v0_x, bus.v0_y,
            bus.x1, bus.y1, bus.v1_x, bus.v1_y};
  endfunction

  task automatic checkAllZero(input string tag);
    checkOutput({tag, "Valid"},  bus.pair_valid, 0);
    checkOutput({tag, "Busy"},   bus.busy, 0);
    checkOutput({tag, "Done"},   bus.done, 0);
    checkOutput({tag, "Count"},  bus.pair_count, 0);
    checkOutput({tag, "Addr"},   bus.rd_addr, 0);
    checkOutput({tag, "Fields"}, observedPair(), 0);
  endtask

  // One scan: stall<0 picks a random stall per pair; abortOnPair resets at the first pair.
  task automatic applyStimulus(input int n, input logic signed [WIDTH-1:0] dsq,
                               input int stall, input bit abortOnPair);
    logic [263:0] expQ[$];
    int pairs, expCount, emitCycles, doneCycle, held, curStall, expCycle;
    bit seenDone;
    pairs = 0;
    for (int i = 0; i < n; i++) begin
      for (int j = i + 1; j < n; j++) begin
        pairs++;
        if (refHit(i, j, dsq)) expQ.push_back(packPair(i, j));
      end
    end
    expCount   = expQ.size();
    emitCycles = 0;
    doneCycle  = 0;
    held       = 0;
    curStall   = 0;
    seenDone   = 1'b0;

    @(negedge clk);
    bus.n_balls    = (IDX_W+1)'(n);
    bus.diam_sq    = dsq;
    bus.pair_ready = 1'b0;
    bus.start      = 1'b1;

    for (int k = 1; k <= 4000 && !seenDone; k++) begin
      @(negedge clk);
      bus.start = 1'b0;
      if (n >= 2 && k == 1) checkOutput("rdAddrFirst", bus.rd_addr, 0);
      if (n >= 2 && k == 2) checkOutput("rdAddrSecond", bus.rd_addr, 1);
      if (n < 2) checkOutput("rdAddrQuiet", bus.rd_addr, 0);
      if (k == 3) begin
        bus.start   = 1'b1;
        bus.n_balls = (IDX_W+1)'($urandom_range(0, 16));
      end
      if (bus.pair_valid) begin
        emitCycles++;
        if (expQ.size() == 0) begin
          checkOutput("unexpectedPair", observedPair(), 0);
          bus.pair_ready = 1'b1;
        end else begin
          checkOutput("pairFields", observedPair(), expQ[0]);
          if (abortOnPair) begin
            bus.pair_ready = 1'b0;
            rst = 1'b1;
            @(negedge clk);
            rst = 1'b0;
            checkAllZero("midReset");
            for (int w = 0; w < 4; w++) begin
              @(negedge clk);
              checkOutput("noDoneAfterReset", bus.done, 0);
            end
            return;
          end
          if (held == 0) curStall = (stall < 0) ? int'($urandom_range(0, 3)) : stall;
          if (held >= curStall) begin
            bus.pair_ready = 1'b1;
            held = 0;
            void'(expQ.pop_front());
          end else begin
            bus.pair_ready = 1'b0;
            held++;
          end
        end
      end else begin
        bus.pair_ready = 1'($urandom_range(0, 1));
      end
      if (bus.done) begin
        seenDone  = 1'b1;
        doneCycle = k;
        bus.start = 1'b1;
      end
    end

    if (!seenDone) begin
      checkOutput("doneTimeout", 0, 1);
    end else begin
      expCycle = (n < 2) ? 2 : 2 * pairs + emitCycles + (n - 1) + 2;
      checkOutput("doneCycle", doneCycle, expCycle);
      checkOutput("pairCount", bus.pair_count, expCount);
      checkOutput("pairsMissing", expQ.size(), 0);
      @(negedge clk);
      bus.start = 1'b0;
      checkOutput("busyAfterDone", bus.busy, 0);
      checkOutput("donePulseWidth", bus.done, 0);
      checkOutput("countHolds", bus.pair_count, expCount);
    end
    bus.pair_ready = 1'b0;
  endtask

  localparam logic signed [WIDTH-1:0] DSQ = 32'sh0100_0000;

  initial begin
    int n;
    logic signed [WIDTH-1:0] dsq;
    checks   = 0;
    failures = 0;
    rst      = 1'b1;
    bus.start      = 1'b0;
    bus.n_balls    = '0;
    bus.diam_sq    = '0;
    bus.pair_ready = 1'b0;
    for (int i = 0; i < N_MAX; i++) loadBall(i, 0, 0, 0, 0);
    repeat (3) @(negedge clk);
    checkAllZero("reset");
    rst = 1'b0;

    // Overlapping and approaching
    loadBall(0, 0, 0, 32'sh2000_0000, 0);
    loadBall(1, 32'sh0400_0000, 0, 0, 0);
    applyStimulus(2, DSQ, 0, 1'b0);

    // Separating
    loadBall(0, 0, 0, -32'sh2000_0000, 0);
    applyStimulus(2, DSQ, 0, 1'b0);

    // Exactly touching is not a hit; one LSB closer is
    loadBall(0, 0, 0, 32'sh2000_0000, 0);
    loadBall(1, 32'sh0800_0000, 0, 0, 0);
    applyStimulus(2, DSQ, 0, 1'b0);
    loadBall(1, 32'sh07FF_FFFF, 0, 0, 0);
    applyStimulus(2, DSQ, 0, 1'b0);

    // Three mutually colliding balls under backpressure
    loadBall(0, 0, 0, 32'sh1000_0000, 32'sh1000_0000);
    loadBall(1, 32'sh0200_0000, 0, -32'sh1000_0000, 0);
    loadBall(2, 0, 32'sh0200_0000, 0, -32'sh1000_0000);
    applyStimulus(3, DSQ, 5, 1'b0);

    applyStimulus(0, DSQ, 0, 1'b0);
    applyStimulus(1, DSQ, 0, 1'b0);

    // Reset during EMIT, then a clean rescan
    applyStimulus(3, DSQ, 2, 1'b1);
    applyStimulus(3, DSQ, -1, 1'b0);

    for (int s = 0; s < 25; s++) begin
      n = int'($urandom_range(0, 16));
      if (s % 5 == 4) begin
        dsq = WIDTH'($urandom() >> 1);
        for (int i = 0; i < N_MAX; i++) loadBall(i, $urandom(), $urandom(), $urandom(), $urandom());
      end else begin
        dsq = DSQ;
        for (int i = 0; i < N_MAX; i++)
          loadBall(i, WIDTH'($urandom_range(0, 32'h0C00_0000)) - 32'sh0600_0000,
                   WIDTH'($urandom_range(0, 32'h0C00_0000)) - 32'sh0600_0000,
                   $urandom(), $urandom());
      end
      applyStimulus(n, dsq, -1, 1'b0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/ball_collision_scanner.md
# ball_collision_scanner

Scans all ball pairs in the ball-state memory once per `start` and emits every colliding, approaching pair to `calc_after_collision_v` through a valid/ready handshake. Collision means squared centre distance strictly below `diam_sq` and relative velocity pointing inward. It sits between the ball-state RAM and the post-collision velocity stage; the emitted fields are named to wire directly to that stage's inputs.

## Interface
- `WIDTH`, 32, fixed-point word width (signed, two's complement)
- `FRAC_WIDTH`, 30, fractional bits
- `N_MAX`, 16, maximum ball count
- `IDX_W`, 4, index width, `$clog2(N_MAX)`

- `clk`  in  1  single clock; all state on rising edge
- `rst`  in  1  synchronous, active-high reset
- `start`  in  1  one-cycle pulse; begins a scan; ignored while `busy`
- `n_balls`  in  IDX_W+1  ball count, sampled on accepted `start`
- `diam_sq`  in  WIDTH  (2r)^2 in Q(WIDTH-FRAC_WIDTH).FRAC_WIDTH, sampled on `start`
- `rd_addr`  out  IDX_W  ball-memory read address
- `rd_x`, `rd_y`, `rd_vx`, `rd_vy`  in  WIDTH each  memory data; valid one cycle after `rd_addr`
- `pair_valid`  out  1  pair fields valid
- `pair_ready`  in  1  downstream accepts the pair
- `pair_i`, `pair_j`  out  IDX_W each  indices of the pair, with i < j
- `x0`, `y0`, `v0_x`, `v0_y`, `x1`, `y1`, `v1_x`, `v1_y`  out  WIDTH each  state of ball i (0) and ball j (1)
- `busy`  out  1  high from accepted `start` until `done`
- `done`  out  1  one-cycle pulse at scan end
- `pair_count`  out  IDX_W*2  pairs emitted this scan; holds until next `start`

## Operation
- FSM states:
  - IDLE
    - on `start`: latch `n_balls` and `diam_sq`; set i=0, j=1; clear `pair_count`.
    - if `n_balls` < 2, go to FIN; otherwise go to ADDR_I.
  - ADDR_I: drive `rd_addr` = i; go to ADDR_J.
  - ADDR_J: latch `rd_*` into ball-i registers; drive `rd_addr` = j; go to CHECK.
  - CHECK: `rd_*` is ball j; evaluate the hit test.
    - hit: latch ball j, go to EMIT.
    - no hit: go to ADVANCE logic.
  - EMIT: `pair_valid` = 1; hold until `pair_ready`. On handshake, `pair_count`++ and go to ADVANCE logic.
  - ADVANCE (combinational, taken from CHECK or EMIT):
    - if j+1 < n: j++, go to ADDR_J.
    - else if i+2 < n: i++, j = i+1 (new value), go to ADDR_I.
    - else go to FIN.
  - FIN: `done` = 1 for one cycle; go to IDLE.
- Hit test arithmetic:
  - dx = x_j − x_i and dy = y_j − y_i, each WIDTH+1 bits signed; likewise dvx and dvy.
  - d2 = dx² + dy², computed at 2·WIDTH+3 bits with no truncation.
  - hit = (d2 < `diam_sq` <<< FRAC_WIDTH) AND (dx·dvx + dy·dvy < 0).
  - Equality is not a hit; a zero dot product is not a hit.
- While `pair_valid` && !`pair_ready`, every output is held stable.
- `pair_valid` never depends combinationally on `pair_ready`.
- Reset values:
  - all outputs 0 (`rd_addr`, pair fields, `pair_count`, `busy`, `done`, `pair_valid`)
  - FSM in IDLE.
- Reset mid-scan: immediate return to IDLE.
  - any pending pair is dropped.
  - no `done` pulse.
- `start` asserted while `busy` has no effect.
- `start` in the same cycle as the FIN `done` pulse is ignored.

## Timing
- `start` at cycle t:
  - `rd_addr`=0 at t+1.
  - `rd_addr`=1 at t+2.
  - CHECK at t+3.
  - First possible `pair_valid` at t+4.
- Non-hit pair: 2 cycles (ADDR_J, CHECK). Changing i adds 1 cycle (ADDR_I).
- Hit pair: 3 cycles plus downstream stall cycles.
- Full scan with no hits: 2·n(n−1)/2 + (n−1) + 2 cycles from `start` to `done`.
- n < 2: `done` at t+2, `pair_count`=0.

## Structure
- Shared package `billiard_pkg` holds:
  - `WIDTH`/`FRAC_WIDTH` defaults.
  - ONE = 1 <<< FRAC_WIDTH.
  - FSM state encoding.
- Natural sub-module: `pair_hit_test`, combinational.
  - Inputs: the two ball states and `diam_sq`.
  - Outputs: `hit`, plus debug `d2` and `dot`.
  - Reusable by the wall/pocket stages.
- Top holds the FSM, i/j counters, ball-i/j registers and the handshake.

## Test plan
Values in Q2.30: 0.0625 = 0x0400_0000, diameter 0.125 gives `diam_sq` = 0x0100_0000.
1. Overlapping and approaching pair:
   - n=2; ball0 = (0,0) with v = (0x2000_0000, 0); ball1 = (0x0400_0000, 0) with v = 0.
   - Expect one pair (0,1) at t+4, fields equal the memory contents, then `done` with `pair_count`=1.
2. Same positions but separating:
   - ball0 v = (−0x2000_0000, 0).
   - Expect no `pair_valid`; `done` at t+5; `pair_count`=0.
3. Boundary distance:
   - ball1 x = 0x0800_0000, so d2 equals `diam_sq` exactly.
   - Expect no hit.
4. Backpressure:
   - n=3 with all three balls mutually overlapping and approaching; `pair_ready` low for 5 cycles on every pair.
   - Expect pairs (0,1), (0,2), (1,2) in order, fields stable while stalled, `pair_count`=3.
5. n_balls = 0 and n_balls = 1:
   - Expect `done` at t+2, no `rd_addr` activity, `busy` low afterwards.
6. Reset and restart:
   - Assert `rst` while in EMIT with `pair_valid` high.
   - Expect all outputs 0 the next cycle and no `done`.
   - A new `start` then rescans from (0,1).
